clk_gate_ctrl: RTL

- Generates the glitch-free enable (CLK_EN) that drives the latch-based clock gate on a gated functional block, e.g. the ALU clock in the multi-clock system.
- Consumers request the clock through REQ, and the gated block holds it with BUSY.
- The controller turns the clock on, reports CLK_RDY after a fixed warm-up, and after a programmable idle window gates the clock off.
- A saturating wake-event counter is kept for power statistics.

---
 rtl/clk_gate_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: wakes the gated clock on demand, reports ready after
// a fixed warm-up, gates it off after a programmable idle window, and counts wake-ups.
module clk_gate_ctrl #(
    parameter int CNT_W    = 4,
    parameter int WAKE_CYC = 2,
    parameter int STAT_W   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              BUSY,
    input  logic              FORCE_ON,
    input  logic [CNT_W-1:0]  IDLE_CYC,
    input  logic              CNT_CLR,
    output logic              CLK_EN,
    output logic              CLK_RDY,
    output logic [STAT_W-1:0] WAKE_COUNT
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    localparam logic [3:0]       WAKE_LAST = 4'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] ICNT_ONE  = CNT_W'(1);

    state_t             state_q;
    logic [3:0]         wcnt_q;
    logic [CNT_W-1:0]   icnt_q;
    logic               clk_en_q;
    logic               clk_rdy_q;
    logic [STAT_W-1:0]  wake_cnt_q;

    logic act;
    logic wake_sat;

    assign act      = REQ | BUSY | FORCE_ON;
    assign wake_sat = &wake_cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_OFF;
            wcnt_q     <= '0;
            icnt_q     <= '0;
            clk_en_q   <= 1'b0;
            clk_rdy_q  <= 1'b0;
            wake_cnt_q <= '0;
        end else begin
            // Clear wins over a coincident wake-up increment.
            if (CNT_CLR) begin
                wake_cnt_q <= '0;
            end else if (state_q == ST_OFF && act && !wake_sat) begin
                wake_cnt_q <= wake_cnt_q + STAT_W'(1);
            end

            case (state_q)
                ST_OFF: begin
                    if (act) begin
                        state_q   <= ST_WAKE;
                        wcnt_q    <= '0;
                        clk_en_q  <= 1'b1;
                        clk_rdy_q <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    // Warm-up always runs to completion, regardless of act.
                    if (wcnt_q == WAKE_LAST) begin
                        state_q   <= ST_ON;
                        clk_rdy_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + 4'd1;
                    end
                end
                ST_ON: begin
                    if (!act) begin
                        if (IDLE_CYC == '0) begin
                            state_q   <= ST_OFF;
                            clk_en_q  <= 1'b0;
                            clk_rdy_q <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            icnt_q  <= IDLE_CYC;
                        end
                    end
                end
                ST_IDLE: begin
                    if (act) begin
                        state_q <= ST_ON;
                    end else if (icnt_q == ICNT_ONE) begin
                        state_q   <= ST_OFF;
                        clk_en_q  <= 1'b0;
                        clk_rdy_q <= 1'b0;
                    end else begin
                        icnt_q <= icnt_q - ICNT_ONE;
                    end
                end
                default: begin
                    state_q   <= ST_OFF;
                    clk_en_q  <= 1'b0;
                    clk_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign CLK_EN     = clk_en_q;
    assign CLK_RDY    = clk_rdy_q;
    assign WAKE_COUNT = wake_cnt_q;

endmodule
